// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: owns the architectural PC, keeps at most one IMEM fetch in flight, hands words to decode.
// Latency: request accepted -> IMEM response (>=1 cycle) -> inst_valid on the following edge.
// Backpressure: request held with a stable address until imem_req_ready; fetched word held until inst_ready.
// Optional: define FETCH_PERF_CNT_EN to add the fetch_cnt / drop_cnt performance counters.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] drop_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Low address bits are forced to zero so a misconfigured parameter still fetches word aligned.
    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst_pc;
    logic [31:0] r_inst;
    logic        r_drop;
    logic        r_req_vld;
    logic        r_inst_vld;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_inst_pc_nxt;
    logic [31:0] w_inst_nxt;
    logic        w_drop_nxt;
    logic        w_req_fire;
    logic        w_handoff;

    // r_req_vld is only ever high in S_REQ, so it doubles as the "request live" qualifier.
    assign w_req_fire = r_req_vld && imem_req_ready;
    assign w_handoff  = r_inst_vld && inst_ready;

    // State register plus all datapath registers; valids are registered copies of the next state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_REQ;
            r_pc       <= PC_INIT;
            r_inst_pc  <= 32'h0;
            r_inst     <= 32'h0;
            r_drop     <= 1'b0;
            r_req_vld  <= 1'b0;
            r_inst_vld <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_inst_pc  <= w_inst_pc_nxt;
            r_inst     <= w_inst_nxt;
            r_drop     <= w_drop_nxt;
            r_req_vld  <= (w_state_nxt == S_REQ);
            r_inst_vld <= (w_state_nxt == S_HOLD);
        end
    end

    // Next-state logic: sequential fetch, response capture, and redirect/squash handling.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_inst_pc_nxt = r_inst_pc;
        w_inst_nxt    = r_inst;
        w_drop_nxt    = r_drop;
        case (r_state)
            S_REQ: begin
                if (w_req_fire) begin
                    w_inst_pc_nxt = r_pc;
                    w_pc_nxt      = r_pc + 32'd4;
                    w_state_nxt   = S_WAIT;
                    // The old-path request is already in flight; its response must be thrown away.
                    if (redir_valid) begin
                        w_drop_nxt = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (r_drop || redir_valid) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_inst_nxt  = imem_rsp_data;
                        w_state_nxt = S_HOLD;
                    end
                end else if (redir_valid) begin
                    w_drop_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                // A same-cycle handoff still completes; otherwise a redirect squashes the held word.
                if (w_handoff || redir_valid) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
        // Redirect target always overrides the sequential increment; last redirect wins.
        if (redir_valid) begin
            w_pc_nxt = redir_pc & ~32'd3;
        end
    end

    assign imem_req_valid = r_req_vld;
    assign imem_req_addr  = r_pc;
    assign inst_valid     = r_inst_vld;
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;
    assign pc             = r_pc;

`ifdef FETCH_PERF_CNT_EN
    logic        w_rsp_discard;
    logic        w_hold_squash;
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_drop_cnt;

    assign w_rsp_discard = (r_state == S_WAIT) && imem_rsp_valid && (r_drop || redir_valid);
    assign w_hold_squash = r_inst_vld && redir_valid && !inst_ready;

    // Performance counters: delivered instructions and wrong-path words thrown away; both wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fetch_cnt <= 32'h0;
            r_drop_cnt  <= 32'h0;
        end else begin
            if (w_handoff) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_rsp_discard || w_hold_squash) begin
                r_drop_cnt <= r_drop_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign drop_cnt  = r_drop_cnt;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Testbench for fetch_pc_ctrl: IMEM/decode model with request and instruction scoreboards.
// Inputs are driven and outputs sampled on the falling clock edge.
// A second instance with RESET_PC at the top of the address space covers PC wrap.
module tb_fetch_pc_ctrl;

    logic        clk;
    logic        rstn;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] pc;

    logic        b_rstn;
    logic        b_redir_valid;
    logic [31:0] b_redir_pc;
    logic        b_req_valid;
    logic        b_req_ready;
    logic [31:0] b_req_addr;
    logic        b_rsp_valid;
    logic [31:0] b_rsp_data;
    logic        b_inst_valid;
    logic        b_inst_ready;
    logic [31:0] b_inst;
    logic [31:0] b_inst_pc;
    logic [31:0] b_pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] drop_cnt;
    logic [31:0] b_fetch_cnt;
    logic [31:0] b_drop_cnt;
`endif

    fetch_pc_ctrl #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rstn(rstn), .redir_valid(redir_valid), .redir_pc(redir_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .pc(pc)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt(fetch_cnt), .drop_cnt(drop_cnt)
`endif
    );

    fetch_pc_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rstn(b_rstn), .redir_valid(b_redir_valid), .redir_pc(b_redir_pc),
        .imem_req_valid(b_req_valid), .imem_req_ready(b_req_ready), .imem_req_addr(b_req_addr),
        .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(b_rsp_data),
        .inst_valid(b_inst_valid), .inst_ready(b_inst_ready), .inst(b_inst), .inst_pc(b_inst_pc), .pc(b_pc)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt(b_fetch_cnt), .drop_cnt(b_drop_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Memory / decode model state
    bit          rdy_en = 1'b0;
    bit          dec_en = 1'b0;
    int          lat    = 1;
    bit          pend   = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_data = 32'h0;
    int          cyc    = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] obs_addr_q[$];
    int          obs_addr_cyc[$];
    logic [63:0] exp_inst_q[$];   // {inst_pc, inst}
    logic [63:0] obs_inst_q[$];
    int          obs_inst_cyc[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    // One cycle: at the falling edge, drive IMEM/decode inputs and record accepted requests/handoffs.
    task automatic tick(input bit rv, input logic [31:0] rp);
        @(negedge clk);
        cyc++;
        redir_valid    = rv;
        redir_pc       = rp;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (pend) begin
            if (pend_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = pend_data;
                pend           = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        imem_req_ready = rdy_en;
        if (rstn && imem_req_valid && rdy_en) begin
            obs_addr_q.push_back(imem_req_addr);
            obs_addr_cyc.push_back(cyc);
            pend      = 1'b1;
            pend_cnt  = lat - 1;
            pend_data = mem_word(imem_req_addr);
        end
        inst_ready = dec_en;
        if (rstn && inst_valid && dec_en) begin
            obs_inst_q.push_back({inst_pc, inst});
            obs_inst_cyc.push_back(cyc);
        end
    endtask

    task automatic clear_queues();
        exp_addr_q.delete(); obs_addr_q.delete(); obs_addr_cyc.delete();
        exp_inst_q.delete(); obs_inst_q.delete(); obs_inst_cyc.delete();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        pend = 1'b0;
        rdy_en = 1'b0;
        dec_en = 1'b0;
        tick(1'b0, 32'h0);
        tick(1'b0, 32'h0);
        rstn = 1'b1;
        clear_queues();
    endtask

    task automatic run_until(input int n, input int budget, output bit ok);
        int k = 0;
        while (obs_inst_q.size() < n && k < budget) begin
            tick(1'b0, 32'h0);
            k++;
        end
        ok = (obs_inst_q.size() >= n);
    endtask

    function automatic logic [63:0] exp_inst(input logic [31:0] a);
        return {a, mem_word(a)};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 32'h0);
            n_checks++;
            if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid);
            else n_pass++;
        end
        n_checks++;
        if (pc !== 32'h100) $display("FAIL reset_pc: got %h expected 00000100", pc); else n_pass++;
        n_checks++;
        if (inst_valid !== 1'b0) $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); else n_pass++;
        n_checks++;
        if (inst !== 32'h0) $display("FAIL reset_inst: got %h expected 00000000", inst); else n_pass++;
        n_checks++;
        if (inst_pc !== 32'h0) $display("FAIL reset_inst_pc: got %h expected 00000000", inst_pc); else n_pass++;
`ifdef FETCH_PERF_CNT_EN
        n_checks++;
        if ({fetch_cnt, drop_cnt} !== 64'h0) $display("FAIL reset_cnt: got %h/%h expected 0/0", fetch_cnt, drop_cnt);
        else n_pass++;
`endif
        rstn = 1'b1;
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b0) $display("FAIL release_req_valid: got %b expected 0", imem_req_valid);
        else n_pass++;
        tick(1'b0, 32'h0);
        n_checks++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h100})
            $display("FAIL first_req: got %b/%h expected 1/00000100", imem_req_valid, imem_req_addr);
        else n_pass++;
    endtask

    task automatic test_sequential();
        bit ok;
        logic [31:0] e, o;
        logic [63:0] ei, oi;
        int d;
        do_reset();
        rdy_en = 1'b1; dec_en = 1'b1; lat = 1;
        for (int i = 0; i < 3; i++) begin
            exp_addr_q.push_back(32'h100 + 32'(4 * i));
            exp_inst_q.push_back(exp_inst(32'h100 + 32'(4 * i)));
        end
        run_until(3, 40, ok);
        n_checks++;
        if (!ok) $display("FAIL seq_timeout: got %0d instructions expected 3", obs_inst_q.size()); else n_pass++;
        d = -1;
        if (obs_inst_cyc.size() > 0 && obs_addr_cyc.size() > 0) d = obs_inst_cyc[0] - obs_addr_cyc[0];
        n_checks++;
        if (d != 2) $display("FAIL seq_latency: got %0d cycles expected 2", d); else n_pass++;
        while (exp_addr_q.size() != 0) begin
            e = exp_addr_q.pop_front();
            o = 'x;
            if (obs_addr_q.size() != 0) o = obs_addr_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL seq_addr: got %h expected %h", o, e); else n_pass++;
        end
        while (exp_inst_q.size() != 0) begin
            ei = exp_inst_q.pop_front();
            oi = 'x;
            if (obs_inst_q.size() != 0) oi = obs_inst_q.pop_front();
            n_checks++;
            if (oi !== ei) $display("FAIL seq_inst: got %h expected %h", oi, ei); else n_pass++;
        end
    endtask

    task automatic test_stall();
        bit ok;
        logic [31:0] e, o;
        logic [63:0] ei, oi;
        do_reset();
        rdy_en = 1'b0; dec_en = 1'b1; lat = 1;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 32'h0);
            n_checks++;
            if ({imem_req_valid, imem_req_addr, pc} !== {1'b1, 32'h100, 32'h100})
                $display("FAIL stall_hold: got %b/%h/%h expected 1/00000100/00000100", imem_req_valid, imem_req_addr, pc);
            else n_pass++;
        end
        rdy_en = 1'b1;
        exp_addr_q.push_back(32'h100);
        exp_inst_q.push_back(exp_inst(32'h100));
        run_until(1, 20, ok);
        n_checks++;
        if (!ok) $display("FAIL stall_timeout: got %0d instructions expected 1", obs_inst_q.size()); else n_pass++;
        n_checks++;
        if (pc !== 32'h104) $display("FAIL stall_pc: got %h expected 00000104", pc); else n_pass++;
        while (exp_addr_q.size() != 0) begin
            e = exp_addr_q.pop_front();
            o = 'x;
            if (obs_addr_q.size() != 0) o = obs_addr_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL stall_addr: got %h expected %h", o, e); else n_pass++;
        end
        while (exp_inst_q.size() != 0) begin
            ei = exp_inst_q.pop_front();
            oi = 'x;
            if (obs_inst_q.size() != 0) oi = obs_inst_q.pop_front();
            n_checks++;
            if (oi !== ei) $display("FAIL stall_inst: got %h expected %h", oi, ei); else n_pass++;
        end
    endtask

    task automatic test_redir_wait();
        bit ok;
        logic [31:0] e, o;
        logic [63:0] ei, oi;
        do_reset();
        rdy_en = 1'b1; dec_en = 1'b1; lat = 3;
        exp_addr_q.push_back(32'h100);
        exp_addr_q.push_back(32'h200);
        exp_inst_q.push_back(exp_inst(32'h200));
        tick(1'b0, 32'h0);
        tick(1'b1, 32'h200);
        run_until(1, 30, ok);
        n_checks++;
        if (!ok) $display("FAIL rwait_timeout: got %0d instructions expected 1", obs_inst_q.size()); else n_pass++;
        while (exp_addr_q.size() != 0) begin
            e = exp_addr_q.pop_front();
            o = 'x;
            if (obs_addr_q.size() != 0) o = obs_addr_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL rwait_addr: got %h expected %h", o, e); else n_pass++;
        end
        while (exp_inst_q.size() != 0) begin
            ei = exp_inst_q.pop_front();
            oi = 'x;
            if (obs_inst_q.size() != 0) oi = obs_inst_q.pop_front();
            n_checks++;
            if (oi !== ei) $display("FAIL rwait_inst: got %h expected %h", oi, ei); else n_pass++;
        end
`ifdef FETCH_PERF_CNT_EN
        @(posedge clk); #1;
        n_checks++;
        if ({fetch_cnt, drop_cnt} !== {32'd1, 32'd1}) $display("FAIL rwait_cnt: got %0d/%0d expected 1/1", fetch_cnt, drop_cnt);
        else n_pass++;
`endif
        lat = 1;
    endtask

    task automatic test_redir_req();
        bit ok;
        logic [31:0] e, o;
        logic [63:0] ei, oi;
        do_reset();
        rdy_en = 1'b1; dec_en = 1'b1; lat = 1;
        exp_addr_q.push_back(32'h100);
        exp_addr_q.push_back(32'h300);
        exp_inst_q.push_back(exp_inst(32'h300));
        tick(1'b1, 32'h300);
        run_until(1, 20, ok);
        n_checks++;
        if (!ok) $display("FAIL rreq_timeout: got %0d instructions expected 1", obs_inst_q.size()); else n_pass++;
        rdy_en = 1'b0;
        tick(1'b1, 32'h501);
        n_checks++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h304})
            $display("FAIL rreq_pre: got %b/%h expected 1/00000304", imem_req_valid, imem_req_addr);
        else n_pass++;
        tick(1'b0, 32'h0);
        n_checks++;
        if ({imem_req_valid, imem_req_addr, pc} !== {1'b1, 32'h500, 32'h500})
            $display("FAIL rreq_switch: got %b/%h/%h expected 1/00000500/00000500", imem_req_valid, imem_req_addr, pc);
        else n_pass++;
        rdy_en = 1'b1;
        exp_addr_q.push_back(32'h500);
        exp_inst_q.push_back(exp_inst(32'h500));
        run_until(2, 20, ok);
        n_checks++;
        if (!ok) $display("FAIL rreq_timeout2: got %0d instructions expected 2", obs_inst_q.size()); else n_pass++;
        while (exp_addr_q.size() != 0) begin
            e = exp_addr_q.pop_front();
            o = 'x;
            if (obs_addr_q.size() != 0) o = obs_addr_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL rreq_addr: got %h expected %h", o, e); else n_pass++;
        end
        while (exp_inst_q.size() != 0) begin
            ei = exp_inst_q.pop_front();
            oi = 'x;
            if (obs_inst_q.size() != 0) oi = obs_inst_q.pop_front();
            n_checks++;
            if (oi !== ei) $display("FAIL rreq_inst: got %h expected %h", oi, ei); else n_pass++;
        end
    endtask

    task automatic test_hold_redir();
        bit ok;
        logic [31:0] e, o;
        logic [63:0] ei, oi;
        do_reset();
        rdy_en = 1'b1; dec_en = 1'b0; lat = 1;
        exp_addr_q.push_back(32'h100);
        exp_addr_q.push_back(32'h40);
        exp_inst_q.push_back(exp_inst(32'h40));
        tick(1'b0, 32'h0);
        tick(1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 32'h0);
            n_checks++;
            if ({inst_valid, inst_pc, inst} !== {1'b1, exp_inst(32'h100)})
                $display("FAIL hold_stable: got %b/%h/%h expected 1/%h", inst_valid, inst_pc, inst, exp_inst(32'h100));
            else n_pass++;
        end
        tick(1'b1, 32'h43);
        dec_en = 1'b1;
        tick(1'b0, 32'h0);
        n_checks++;
        if (inst_valid !== 1'b0) $display("FAIL hold_squash: got %b expected 0", inst_valid); else n_pass++;
        run_until(1, 20, ok);
        n_checks++;
        if (!ok) $display("FAIL hold_timeout: got %0d instructions expected 1", obs_inst_q.size()); else n_pass++;
        while (exp_addr_q.size() != 0) begin
            e = exp_addr_q.pop_front();
            o = 'x;
            if (obs_addr_q.size() != 0) o = obs_addr_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL hold_addr: got %h expected %h", o, e); else n_pass++;
        end
        while (exp_inst_q.size() != 0) begin
            ei = exp_inst_q.pop_front();
            oi = 'x;
            if (obs_inst_q.size() != 0) oi = obs_inst_q.pop_front();
            n_checks++;
            if (oi !== ei) $display("FAIL hold_inst: got %h expected %h", oi, ei); else n_pass++;
        end
`ifdef FETCH_PERF_CNT_EN
        @(posedge clk); #1;
        n_checks++;
        if ({fetch_cnt, drop_cnt} !== {32'd1, 32'd1}) $display("FAIL hold_cnt: got %0d/%0d expected 1/1", fetch_cnt, drop_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_handoff_redir();
        bit ok;
        logic [31:0] e, o;
        logic [63:0] ei, oi;
        do_reset();
        rdy_en = 1'b1; dec_en = 1'b1; lat = 1;
        exp_addr_q.push_back(32'h100);
        exp_addr_q.push_back(32'h80);
        exp_inst_q.push_back(exp_inst(32'h100));
        exp_inst_q.push_back(exp_inst(32'h80));
        tick(1'b0, 32'h0);
        tick(1'b0, 32'h0);
        tick(1'b1, 32'h80);
        run_until(2, 20, ok);
        n_checks++;
        if (!ok) $display("FAIL hoff_timeout: got %0d instructions expected 2", obs_inst_q.size()); else n_pass++;
        while (exp_addr_q.size() != 0) begin
            e = exp_addr_q.pop_front();
            o = 'x;
            if (obs_addr_q.size() != 0) o = obs_addr_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL hoff_addr: got %h expected %h", o, e); else n_pass++;
        end
        while (exp_inst_q.size() != 0) begin
            ei = exp_inst_q.pop_front();
            oi = 'x;
            if (obs_inst_q.size() != 0) oi = obs_inst_q.pop_front();
            n_checks++;
            if (oi !== ei) $display("FAIL hoff_inst: got %h expected %h", oi, ei); else n_pass++;
        end
`ifdef FETCH_PERF_CNT_EN
        @(posedge clk); #1;
        n_checks++;
        if ({fetch_cnt, drop_cnt} !== {32'd2, 32'd0}) $display("FAIL hoff_cnt: got %0d/%0d expected 2/0", fetch_cnt, drop_cnt);
        else n_pass++;
`endif
    endtask

    // Continues from the previous scenario's live fetch stream, then resets while a response is pending.
    task automatic test_reset_mid();
        bit ok;
        logic [31:0] e, o;
        logic [63:0] ei, oi;
        clear_queues();
        rdy_en = 1'b1; dec_en = 1'b1; lat = 3;
        tick(1'b0, 32'h0);
        tick(1'b0, 32'h0);
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({imem_req_valid, inst_valid, pc, inst_pc, inst} !== {2'b00, 32'h100, 32'h0, 32'h0})
            $display("FAIL midrst_outputs: got %b/%b/%h/%h/%h expected 0/0/00000100/00000000/00000000",
                     imem_req_valid, inst_valid, pc, inst_pc, inst);
        else n_pass++;
`ifdef FETCH_PERF_CNT_EN
        n_checks++;
        if ({fetch_cnt, drop_cnt} !== 64'h0) $display("FAIL midrst_cnt: got %0d/%0d expected 0/0", fetch_cnt, drop_cnt);
        else n_pass++;
`endif
        tick(1'b0, 32'h0);
        rstn = 1'b1;
        rdy_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 32'h0);
            n_checks++;
            if ({inst_valid, imem_req_valid, imem_req_addr} !== {2'b01, 32'h100})
                $display("FAIL midrst_ignore: got %b/%b/%h expected 0/1/00000100", inst_valid, imem_req_valid, imem_req_addr);
            else n_pass++;
        end
        rdy_en = 1'b1;
        clear_queues();
        exp_addr_q.push_back(32'h100);
        exp_inst_q.push_back(exp_inst(32'h100));
        run_until(1, 30, ok);
        n_checks++;
        if (!ok) $display("FAIL midrst_timeout: got %0d instructions expected 1", obs_inst_q.size()); else n_pass++;
        while (exp_addr_q.size() != 0) begin
            e = exp_addr_q.pop_front();
            o = 'x;
            if (obs_addr_q.size() != 0) o = obs_addr_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL midrst_addr: got %h expected %h", o, e); else n_pass++;
        end
        while (exp_inst_q.size() != 0) begin
            ei = exp_inst_q.pop_front();
            oi = 'x;
            if (obs_inst_q.size() != 0) oi = obs_inst_q.pop_front();
            n_checks++;
            if (oi !== ei) $display("FAIL midrst_inst: got %h expected %h", oi, ei); else n_pass++;
        end
        lat = 1;
    endtask

    task automatic test_wrap();
        logic [31:0] bq[$];
        logic [63:0] iq[$];
        logic [31:0] e, o;
        logic [63:0] oi;
        bit bpend = 1'b0;
        exp_addr_q.delete();
        exp_addr_q.push_back(32'hFFFF_FFFC);
        exp_addr_q.push_back(32'h0000_0000);
        n_checks++;
        if (b_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_reset_pc: got %h expected fffffffc", b_pc); else n_pass++;
        @(negedge clk);
        b_rstn = 1'b1; b_req_ready = 1'b1; b_inst_ready = 1'b1;
        for (int i = 0; i < 30 && bq.size() < 2; i++) begin
            @(negedge clk);
            b_rsp_valid = bpend;
            b_rsp_data  = bpend ? 32'hABCD_0001 : 32'h0;
            bpend       = 1'b0;
            if (b_req_valid) begin
                bq.push_back(b_req_addr);
                bpend = 1'b1;
            end
            if (b_inst_valid) iq.push_back({b_inst_pc, b_inst});
        end
        n_checks++;
        if (bq.size() != 2) $display("FAIL wrap_timeout: got %0d requests expected 2", bq.size()); else n_pass++;
        while (exp_addr_q.size() != 0) begin
            e = exp_addr_q.pop_front();
            o = 'x;
            if (bq.size() != 0) o = bq.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL wrap_addr: got %h expected %h", o, e); else n_pass++;
        end
        oi = 'x;
        if (iq.size() != 0) oi = iq.pop_front();
        n_checks++;
        if (oi !== {32'hFFFF_FFFC, 32'hABCD_0001}) $display("FAIL wrap_inst: got %h expected fffffffcabcd0001", oi);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0; redir_valid = 1'b0; redir_pc = 32'h0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; inst_ready = 1'b0;
        b_rstn = 1'b0; b_redir_valid = 1'b0; b_redir_pc = 32'h0;
        b_req_ready = 1'b0; b_rsp_valid = 1'b0; b_rsp_data = 32'h0; b_inst_ready = 1'b0;
        test_reset();
        test_sequential();
        test_stall();
        test_redir_wait();
        test_redir_req();
        test_hold_redir();
        test_handoff_redir();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
